// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake on an opaque DW-bit payload.
// SKID=1 gives a two-entry skid buffer with registered in_ready; SKID=0 a single register.
module pipe_stage_reg #(
  parameter int DW    = 80,
  parameter bit SKID  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Counts cycles in which a valid payload is held back by downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  if (SKID) begin : g_skid
    state_t        state;
    logic          inReadyQ;
    logic [DW-1:0] skidData;
    logic          inXfer;

    assign inXfer   = in_valid & inReadyQ;
    // NOTE: in_ready comes from a flop (it is ~skid_valid), so out_ready never reaches it combinationally.
    assign in_ready = inReadyQ;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        inReadyQ  <= 1'b1;
        // NOTE: payload registers are reset as well so out_data reads 0, not X, after reset.
        out_data  <= '0;
        skidData  <= '0;
      end else if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        inReadyQ  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (inXfer) begin
              out_data  <= in_data;
              out_valid <= 1'b1;
              state     <= HALF;
            end
          end
          HALF: begin
            if (inXfer && out_ready) begin
              out_data <= in_data;
            end else if (inXfer) begin
              skidData <= in_data;
              inReadyQ <= 1'b0;
              state    <= FULL;
            end else if (out_ready) begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end
          FULL: begin
            // Input is never accepted here; in_ready rises on the cycle after the drain.
            if (out_ready) begin
              out_data <= skidData;
              inReadyQ <= 1'b1;
              state    <= HALF;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            inReadyQ  <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
